mmio_slot_bridge: RTL and testbench
===================================

// Module: mmio_slot_bridge
// PURPOSE
//  Parametrised successor to the fixed two-level CPU/device bridges: one block that decodes a CPU
//  data-port access against NSLOT programmable address windows and runs a registered request/ack
//  handshake with the selected device. Adds wait-state support, bus-error reporting (unmapped
//  address, illegal partial write, device timeout) and per-slot interrupt routing onto HWInt[7:2].
//  Sits between the CPU memory stage and all MMIO devices; main data memory stays outside it.
// PARAMETERS
//  NSLOT      6             number of device slots (1..8)
//  SLOT_BASE  {NSLOT x 32}  packed window base addresses; slot i at [32*i +: 32]
//  SLOT_MASK  {NSLOT x 32}  packed address masks; hit_i = ((addr & mask_i) == base_i)
//  SLOT_WORD  {NSLOT x 1}   bit i = 1: slot i accepts only full-word (be==4'b1111) writes
//  TIMEOUT    15            max cycles waiting for dev_ack before bus error (1..255)
// PORTS
//  clk         in   1         system clock
//  reset       in   1         synchronous, active-high reset
//  cpu_req     in   1         access request, sampled in IDLE only
//  cpu_addr    in   32        byte address
//  cpu_we      in   1         1 = write, 0 = read
//  cpu_be      in   4         byte enables (write)
//  cpu_wdata   in   32        write data
//  cpu_ready   out  1         one-cycle pulse: access complete
//  cpu_rdata   out  32        read data, valid with cpu_ready
//  cpu_err     out  1         bus error, valid with cpu_ready
//  HWInt       out  6         interrupt lines to CP0, HWInt[2+i] = dev_irq[i] (i < 6)
//  dev_sel     out  NSLOT     one-hot slot select, held for whole access
//  dev_addr    out  30        latched cpu_addr[31:2]
//  dev_we      out  1         latched write flag
//  dev_be      out  4         latched byte enables
//  dev_wdata   out  32        latched write data
//  dev_ack     in   NSLOT     per-slot completion strobe
//  dev_rdata   in   NSLOT*32  per-slot read data, sampled when its ack is high
//  dev_irq     in   NSLOT     per-slot interrupt request (level)
// BEHAVIOUR
//  Reset: state=IDLE; cpu_ready=0, cpu_err=0, cpu_rdata=0, dev_sel=0, dev_we=0, dev_be=0,
//   dev_addr=0, dev_wdata=0, timeout counter=0, HWInt=0. Reset mid-access aborts it, no response.
//  FSM IDLE -> ACCESS -> RESP -> IDLE:
//   IDLE: cpu_req=1 -> latch addr/we/be/wdata, decode; lowest-index hit wins on overlap.
//    no hit, or write with be!=4'b1111 to a SLOT_WORD slot -> RESP with err=1, dev_sel stays 0.
//    otherwise -> ACCESS, dev_sel=onehot(slot), counter=0.
//   ACCESS: dev_ack[slot]=1 -> capture dev_rdata[slot] (reads; writes give rdata=0), -> RESP err=0.
//    else counter++; counter==TIMEOUT-1 without ack -> RESP err=1, rdata=0. Acks of unselected
//    slots ignored. Minimum latency req->ready = 3 cycles (ack in first ACCESS cycle).
//   RESP: cpu_ready=1 one cycle, dev_sel=0; -> IDLE. cpu_req ignored outside IDLE.
//  cpu_rdata/cpu_err hold last value until next RESP; cpu_ready is 0 outside RESP.
//  Slots >= 6 have no HWInt line; unused HWInt bits (NSLOT<6) tie to 0.
// CONFIGURATION
//  BRIDGE_IRQ_SYNC_EN defined: dev_irq passes a 2-flop synchroniser (reset 0) before HWInt,
//   2-cycle irq->HWInt latency. Undefined: HWInt is combinational from dev_irq, 0-cycle latency.
// STRUCTURE
//  Package bridge_pkg: state enum (IDLE/ACCESS/RESP), clog2 function, BE_FULL=4'b1111 constant.
//  Sub-module mmio_slot_decoder: combinational addr -> {hit, slot index, word_only} from
//   SLOT_BASE/SLOT_MASK/SLOT_WORD; instantiated once in mmio_slot_bridge.
// TESTING  (NSLOT=6, slot0 base 0x7F00 mask 0xFFF0, slot2 base 0x7F20 mask 0xFFFC word-only)
//  read 0x7F04, dev_ack[0] in 1st ACCESS cycle, rdata0=0x1234 -> cpu_ready cycle 3, rdata=0x1234, err=0
//  write 0x7F20 be=0011 -> no dev_sel, cpu_ready cycle 2, err=1; be=1111 -> dev_sel=000100, err=0
//  read 0x0000_3000 (unmapped) -> err=1, rdata=0, dev_sel never asserted
//  slot0 never acks, TIMEOUT=15 -> cpu_ready exactly 15 ACCESS cycles later with err=1
//  reset asserted during ACCESS -> next cycle dev_sel=0, no cpu_ready; new req served normally
//  dev_irq=6'b000101 -> HWInt=6'b000101 same cycle (macro off) / 2 cycles later (macro on)

Source files
------------

// File: rtl/bridge_pkg.sv
// ---------------------------------------------------------------------------
// bridge_pkg
// Shared definitions for the MMIO slot bridge:
//   - bridge_state_e : access sequencer states (IDLE / ACCESS / RESP)
//   - BE_FULL        : byte-enable pattern of a full 32-bit word write
//   - clog2()        : ceiling log2 used to size index and counter fields
// ---------------------------------------------------------------------------
package bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } bridge_state_e;

    localparam logic [3:0] BE_FULL = 4'b1111;

    // Smallest width w with 2**w >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((32'sd1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/mmio_slot_decoder.sv
// ---------------------------------------------------------------------------
// mmio_slot_decoder
// Combinational address decoder for the MMIO slot bridge. Each slot i owns
// the window ((addr & mask_i) == base_i). Windows may overlap; the lowest
// slot index that hits wins.
// Ports:
//   addr      in  32      byte address to decode
//   hit       out 1       some slot claims the address
//   slot      out SLOT_W  index of the winning slot (0 when no hit)
//   word_only out 1       winning slot accepts only full-word writes
// ---------------------------------------------------------------------------
module mmio_slot_decoder
    import bridge_pkg::*;
#(
    parameter int                  NSLOT     = 6,
    parameter int                  SLOT_W    = (NSLOT > 1) ? clog2(NSLOT) : 1,
    parameter logic [NSLOT*32-1:0] SLOT_BASE = '0,
    parameter logic [NSLOT*32-1:0] SLOT_MASK = '0,
    parameter logic [NSLOT-1:0]    SLOT_WORD = '0
) (
    input  logic [31:0]       addr,
    output logic              hit,
    output logic [SLOT_W-1:0] slot,
    output logic              word_only
);

    logic [NSLOT-1:0] hit_vec_s;

    genvar g;
    for (g = 0; g < NSLOT; g++) begin : g_win
        assign hit_vec_s[g] = ((addr & SLOT_MASK[32*g +: 32]) == SLOT_BASE[32*g +: 32]);
    end

    // Priority pick: scanning upwards, only the first hit updates slot/word_only.
    always_comb begin
        hit       = 1'b0;
        slot      = '0;
        word_only = 1'b0;
        for (int i = 0; i < NSLOT; i++) begin
            slot      = (hit_vec_s[i] && !hit) ? SLOT_W'(i)   : slot;
            word_only = (hit_vec_s[i] && !hit) ? SLOT_WORD[i] : word_only;
            hit       = hit | hit_vec_s[i];
        end
    end

endmodule

// File: rtl/mmio_slot_bridge.sv
// ---------------------------------------------------------------------------
// mmio_slot_bridge
// Decodes a CPU data-port access against NSLOT programmable windows and runs
// a registered request/ack handshake with the selected device. Reports bus
// errors for unmapped addresses, partial writes to word-only slots and
// device timeouts. Routes dev_irq[5:0] onto HWInt[7:2] (HWInt[i] here).
//
// Configuration macro: BRIDGE_IRQ_SYNC_EN
//   defined   : dev_irq passes a 2-flop synchroniser before HWInt (2 cycles)
//   undefined : HWInt follows dev_irq combinationally
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   cpu_req/addr/we/be/wdata   CPU access request (sampled in IDLE only)
//   cpu_ready                  one-cycle completion pulse
//   cpu_rdata, cpu_err         response, valid with cpu_ready, held after
//   HWInt[5:0]                 interrupt lines, HWInt[i] = dev_irq[i]
//   dev_sel                    one-hot slot select, held for whole access
//   dev_addr/we/be/wdata       latched request fields for the device
//   dev_ack, dev_rdata         per-slot completion strobe and read data
//   dev_irq                    per-slot level interrupt requests
// ---------------------------------------------------------------------------
module mmio_slot_bridge
    import bridge_pkg::*;
#(
    parameter int                  NSLOT     = 6,
    parameter logic [NSLOT*32-1:0] SLOT_BASE = {32'h00007F50, 32'h00007F40, 32'h00007F30,
                                                32'h00007F20, 32'h00007F10, 32'h00007F00},
    parameter logic [NSLOT*32-1:0] SLOT_MASK = {32'h0000FFF0, 32'h0000FFF0, 32'h0000FFF0,
                                                32'h0000FFF0, 32'h0000FFF0, 32'h0000FFF0},
    parameter logic [NSLOT-1:0]    SLOT_WORD = '0,
    parameter int                  TIMEOUT   = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic [31:0]           cpu_addr,
    input  logic                  cpu_we,
    input  logic [3:0]            cpu_be,
    input  logic [31:0]           cpu_wdata,
    output logic                  cpu_ready,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_err,
    output logic [5:0]            HWInt,
    output logic [NSLOT-1:0]      dev_sel,
    output logic [29:0]           dev_addr,
    output logic                  dev_we,
    output logic [3:0]            dev_be,
    output logic [31:0]           dev_wdata,
    input  logic [NSLOT-1:0]      dev_ack,
    input  logic [NSLOT*32-1:0]   dev_rdata,
    input  logic [NSLOT-1:0]      dev_irq
);

    localparam int                SLOT_W   = (NSLOT > 1) ? clog2(NSLOT) : 1;
    localparam int                CNT_W    = clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [NSLOT-1:0]  SEL_ONE  = NSLOT'(1'b1);

    bridge_state_e      state_r;
    logic [SLOT_W-1:0]  slot_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               cpu_ready_r;
    logic [31:0]        cpu_rdata_r;
    logic               cpu_err_r;
    logic [NSLOT-1:0]   dev_sel_r;
    logic [29:0]        dev_addr_r;
    logic               dev_we_r;
    logic [3:0]         dev_be_r;
    logic [31:0]        dev_wdata_r;

    logic               dec_hit_s;
    logic [SLOT_W-1:0]  dec_slot_s;
    logic               dec_word_s;
    logic               bad_write_s;
    logic               ack_sel_s;
    logic [31:0]        rdata_sel_s;
    logic [5:0]         irq_map_s;

    mmio_slot_decoder #(
        .NSLOT     (NSLOT),
        .SLOT_W    (SLOT_W),
        .SLOT_BASE (SLOT_BASE),
        .SLOT_MASK (SLOT_MASK),
        .SLOT_WORD (SLOT_WORD)
    ) u_decoder (
        .addr      (cpu_addr),
        .hit       (dec_hit_s),
        .slot      (dec_slot_s),
        .word_only (dec_word_s)
    );

    assign bad_write_s = cpu_we && (cpu_be != BE_FULL) && dec_word_s;

    // Ack and read data of the slot latched for the current access only.
    always_comb begin
        ack_sel_s   = 1'b0;
        rdata_sel_s = 32'h0000_0000;
        for (int i = 0; i < NSLOT; i++) begin
            ack_sel_s   = (slot_r == SLOT_W'(i)) ? dev_ack[i]            : ack_sel_s;
            rdata_sel_s = (slot_r == SLOT_W'(i)) ? dev_rdata[32*i +: 32] : rdata_sel_s;
        end
    end

    // Access sequencer: IDLE decodes, ACCESS waits for ack/timeout, RESP pulses cpu_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            slot_r      <= '0;
            cnt_r       <= '0;
            cpu_ready_r <= 1'b0;
            cpu_rdata_r <= 32'h0000_0000;
            cpu_err_r   <= 1'b0;
            dev_sel_r   <= '0;
            dev_addr_r  <= 30'h0000_0000;
            dev_we_r    <= 1'b0;
            dev_be_r    <= 4'b0000;
            dev_wdata_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    cpu_ready_r <= 1'b0;
                    if (cpu_req) begin
                        dev_addr_r  <= cpu_addr[31:2];
                        dev_we_r    <= cpu_we;
                        dev_be_r    <= cpu_be;
                        dev_wdata_r <= cpu_wdata;
                        if (!dec_hit_s || bad_write_s) begin
                            // Rejected without touching any device.
                            state_r     <= RESP;
                            cpu_ready_r <= 1'b1;
                            cpu_err_r   <= 1'b1;
                            cpu_rdata_r <= 32'h0000_0000;
                        end else begin
                            state_r   <= ACCESS;
                            slot_r    <= dec_slot_s;
                            dev_sel_r <= SEL_ONE << dec_slot_s;
                            cnt_r     <= '0;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    if (ack_sel_s) begin
                        state_r     <= RESP;
                        cpu_ready_r <= 1'b1;
                        cpu_err_r   <= 1'b0;
                        cpu_rdata_r <= dev_we_r ? 32'h0000_0000 : rdata_sel_s;
                        dev_sel_r   <= '0;
                    end else if (cnt_r == CNT_LAST) begin
                        // cnt_r counts ACCESS cycles already spent; this is the last allowed one.
                        state_r     <= RESP;
                        cpu_ready_r <= 1'b1;
                        cpu_err_r   <= 1'b1;
                        cpu_rdata_r <= 32'h0000_0000;
                        dev_sel_r   <= '0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                RESP: begin
                    state_r     <= IDLE;
                    cpu_ready_r <= 1'b0;
                    dev_sel_r   <= '0;
                end
                default: begin
                    state_r     <= IDLE;
                    cpu_ready_r <= 1'b0;
                    dev_sel_r   <= '0;
                end
            endcase
        end
    end

    assign cpu_ready = cpu_ready_r;
    assign cpu_rdata = cpu_rdata_r;
    assign cpu_err   = cpu_err_r;
    assign dev_sel   = dev_sel_r;
    assign dev_addr  = dev_addr_r;
    assign dev_we    = dev_we_r;
    assign dev_be    = dev_be_r;
    assign dev_wdata = dev_wdata_r;

    // Only slots 0..5 own an interrupt line; missing slots tie their line low.
    genvar g;
    for (g = 0; g < 6; g++) begin : g_irq
        if (g < NSLOT) begin : g_on
            assign irq_map_s[g] = dev_irq[g];
        end else begin : g_off
            assign irq_map_s[g] = 1'b0;
        end
    end

`ifdef BRIDGE_IRQ_SYNC_EN
    logic [5:0] irq_meta_r;
    logic [5:0] irq_sync_r;

    // Two-flop synchroniser for asynchronous device interrupt levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_meta_r <= 6'b000000;
            irq_sync_r <= 6'b000000;
        end else begin
            irq_meta_r <= irq_map_s;
            irq_sync_r <= irq_meta_r;
        end
    end

    assign HWInt = irq_sync_r;
`else
    assign HWInt = irq_map_s;
`endif

endmodule

// File: tb/tb_mmio_slot_bridge.sv
// ---------------------------------------------------------------------------
// tb_mmio_slot_bridge
// Self-checking bench for mmio_slot_bridge. Slot map:
//   slot0 0x7F00/0xFFF0, slot1 0x7F10/0xFFF0, slot2 0x7F20/0xFFFC word-only,
//   slot3 0x7F30/0xFFF0, slot4 0x8000/0xF000, slot5 0x7F00/0xFFFFFF00 (overlap).
// Expected outcome of each access is derived from the window rules, the
// chosen ack delay and TIMEOUT; the bench also acts as the device.
// ---------------------------------------------------------------------------
module tb_mmio_slot_bridge;

    localparam int NSLOT   = 6;
    localparam int TIMEOUT = 15;
    localparam logic [NSLOT*32-1:0] P_BASE = {32'h00007F00, 32'h00008000, 32'h00007F30,
                                              32'h00007F20, 32'h00007F10, 32'h00007F00};
    localparam logic [NSLOT*32-1:0] P_MASK = {32'hFFFFFF00, 32'h0000F000, 32'h0000FFF0,
                                              32'h0000FFFC, 32'h0000FFF0, 32'h0000FFF0};
    localparam logic [NSLOT-1:0]    P_WORD = 6'b000100;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 cpu_req;
    logic [31:0]          cpu_addr;
    logic                 cpu_we;
    logic [3:0]           cpu_be;
    logic [31:0]          cpu_wdata;
    logic                 cpu_ready;
    logic [31:0]          cpu_rdata;
    logic                 cpu_err;
    logic [5:0]           HWInt;
    logic [NSLOT-1:0]     dev_sel;
    logic [29:0]          dev_addr;
    logic                 dev_we;
    logic [3:0]           dev_be;
    logic [31:0]          dev_wdata;
    logic [NSLOT-1:0]     dev_ack;
    logic [NSLOT*32-1:0]  dev_rdata;
    logic [NSLOT-1:0]     dev_irq;

    int checks = 0;
    int errors = 0;

    mmio_slot_bridge #(
        .NSLOT     (NSLOT),
        .SLOT_BASE (P_BASE),
        .SLOT_MASK (P_MASK),
        .SLOT_WORD (P_WORD),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_we    (cpu_we),
        .cpu_be    (cpu_be),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .cpu_rdata (cpu_rdata),
        .cpu_err   (cpu_err),
        .HWInt     (HWInt),
        .dev_sel   (dev_sel),
        .dev_addr  (dev_addr),
        .dev_we    (dev_we),
        .dev_be    (dev_be),
        .dev_wdata (dev_wdata),
        .dev_ack   (dev_ack),
        .dev_rdata (dev_rdata),
        .dev_irq   (dev_irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode: first slot whose window contains the address, -1 if none.
    function automatic int model_slot(input logic [31:0] a);
        for (int i = 0; i < NSLOT; i++) begin
            if ((a & P_MASK[32*i +: 32]) == P_BASE[32*i +: 32]) return i;
        end
        return -1;
    endfunction

    // One CPU access. ack_delay = ACCESS cycles before the device acks (-1: never).
    task automatic run_access(input string tag, input logic [31:0] addr, input logic we,
                              input logic [3:0] be, input logic [31:0] wdata,
                              input int ack_delay, input logic [31:0] rval);
        int               slot;
        bit               viol;
        int               exp_lat;
        logic             exp_err;
        logic [31:0]      exp_rdata;
        bit               chk_rdata;
        logic [NSLOT-1:0] exp_sel;
        int               cyc;
        int               acc_n;
        bit               done;

        slot = model_slot(addr);
        viol = (slot >= 0) && we && (be != 4'b1111) && P_WORD[slot];
        exp_sel = '0;
        if (slot < 0 || viol) begin
            exp_lat = 2; exp_err = 1'b1; exp_rdata = 32'h0; chk_rdata = (slot < 0);
        end else begin
            exp_sel[slot] = 1'b1;
            chk_rdata = 1'b1;
            if (ack_delay >= 0 && ack_delay < TIMEOUT) begin
                exp_lat = ack_delay + 3; exp_err = 1'b0; exp_rdata = we ? 32'h0 : rval;
            end else begin
                exp_lat = TIMEOUT + 2; exp_err = 1'b1; exp_rdata = 32'h0;
            end
        end

        cpu_req = 1'b1; cpu_addr = addr; cpu_we = we; cpu_be = be; cpu_wdata = wdata;
        step();
        cyc = 2; acc_n = 0; done = 1'b0;
        while (!done && cyc < 300) begin
            if (cpu_ready === 1'b1) begin
                done = 1'b1;
                chk({tag, "_latency"}, cyc, exp_lat);
                chk({tag, "_err"}, 32'(cpu_err), 32'(exp_err));
                if (chk_rdata) chk({tag, "_rdata"}, cpu_rdata, exp_rdata);
                chk({tag, "_sel_resp"}, 32'(dev_sel), 32'h0);
                cpu_req = 1'b0;
                dev_ack = '0;
            end else begin
                chk({tag, "_sel"}, 32'(dev_sel), 32'(exp_sel));
                if (acc_n == 0 && exp_sel != '0) begin
                    chk({tag, "_dev_addr"}, 32'(dev_addr), 32'(addr[31:2]));
                    chk({tag, "_dev_we"}, 32'(dev_we), 32'(we));
                    chk({tag, "_dev_be"}, 32'(dev_be), 32'(be));
                    chk({tag, "_dev_wdata"}, dev_wdata, wdata);
                end
                // CPU side scribbles while busy; the bridge must ignore it.
                cpu_req   = 1'($urandom_range(0, 1));
                cpu_addr  = $urandom;
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_be    = 4'($urandom);
                cpu_wdata = $urandom;
                // Unselected slots ack at random; their data must never leak through.
                dev_ack = NSLOT'($urandom) & ~exp_sel;
                for (int i = 0; i < NSLOT; i++) dev_rdata[32*i +: 32] = $urandom;
                if (slot >= 0 && exp_sel != '0 && acc_n == ack_delay) begin
                    dev_ack[slot] = 1'b1;
                    dev_rdata[32*slot +: 32] = rval;
                end
                acc_n++;
                step();
                cyc++;
            end
        end
        chk({tag, "_ready_seen"}, 32'(done), 32'h1);
        cpu_req = 1'b0;
        dev_ack = '0;
        step();
        chk({tag, "_ready_pulse"}, 32'(cpu_ready), 32'h0);
        chk({tag, "_err_hold"}, 32'(cpu_err), 32'(exp_err));
        if (chk_rdata) chk({tag, "_rdata_hold"}, cpu_rdata, exp_rdata);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] a;
    logic [3:0]  be_r;
    int          pick;
    int          dly;
    logic [5:0]  irq_v;

    initial begin
        reset = 1'b1; cpu_req = 1'b0; cpu_addr = 32'h0; cpu_we = 1'b0; cpu_be = 4'h0;
        cpu_wdata = 32'h0; dev_ack = '0; dev_rdata = '0; dev_irq = '0;
        step(); step();
        chk("rst_ready", 32'(cpu_ready), 32'h0);
        chk("rst_err",   32'(cpu_err),   32'h0);
        chk("rst_rdata", cpu_rdata,      32'h0);
        chk("rst_sel",   32'(dev_sel),   32'h0);
        chk("rst_addr",  32'(dev_addr),  32'h0);
        chk("rst_we",    32'(dev_we),    32'h0);
        chk("rst_be",    32'(dev_be),    32'h0);
        chk("rst_wdata", dev_wdata,      32'h0);
        chk("rst_hwint", 32'(HWInt),     32'h0);
        reset = 1'b0;
        step();

        // Directed cases.
        run_access("rd_slot0",     32'h0000_7F04, 1'b0, 4'hF, 32'h0,          0,  32'h0000_1234);
        run_access("wr_word_part", 32'h0000_7F20, 1'b1, 4'h3, 32'hAAAA_5555,  0,  32'h0);
        run_access("wr_word_full", 32'h0000_7F20, 1'b1, 4'hF, 32'hDEAD_BEEF,  0,  32'h0);
        run_access("rd_unmapped",  32'h0000_3000, 1'b0, 4'hF, 32'h0,          0,  32'h0);
        run_access("rd_timeout",   32'h0000_7F08, 1'b0, 4'hF, 32'h0,         -1,  32'h0);
        run_access("rd_last_ack",  32'h0000_7F14, 1'b0, 4'hF, 32'h0,  TIMEOUT-1,  32'hCAFE_F00D);
        run_access("rd_overlap",   32'h0000_7F24, 1'b0, 4'hF, 32'h0,          2,  32'h5A5A_0001);
        run_access("wr_part_ok",   32'h0000_7F10, 1'b1, 4'h1, 32'h0000_00EE,  1,  32'h0);

        // Reset in the middle of an access aborts it silently.
        cpu_req = 1'b1; cpu_addr = 32'h0000_7F08; cpu_we = 1'b0; cpu_be = 4'hF;
        step();
        cpu_req = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
        chk("midrst_sel",   32'(dev_sel),   32'h0);
        chk("midrst_ready", 32'(cpu_ready), 32'h0);
        reset = 1'b0;
        pick = 0;
        for (int i = 0; i < 20; i++) begin
            if (cpu_ready !== 1'b0 || dev_sel !== '0) pick = 1;
            step();
        end
        chk("midrst_quiet", 32'(pick), 32'h0);
        run_access("after_rst", 32'h0000_7F04, 1'b0, 4'hF, 32'h0, 0, 32'h0000_4321);

        // Randomised accesses over interesting windows.
        for (int t = 0; t < 40; t++) begin
            pick = $urandom_range(0, 8);
            case (pick)
                0: a = 32'h0000_7F00;
                1: a = 32'h0000_7F10;
                2: a = 32'h0000_7F20;
                3: a = 32'h0000_7F24;
                4: a = 32'h0000_7F30;
                5: a = 32'h0000_8000;
                6: a = 32'h0000_3000;
                7: a = 32'h0001_7F00;
                default: a = $urandom;
            endcase
            if (pick < 8) a = a | 32'($urandom_range(0, 15));
            dly = $urandom_range(0, 9);
            case (dly)
                6: dly = TIMEOUT - 1;
                7: dly = TIMEOUT;
                8: dly = -1;
                9: dly = 1;
                default: dly = dly;
            endcase
            be_r = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
            run_access("rand", a, 1'($urandom_range(0, 1)), be_r, $urandom, dly, $urandom);
        end

        // Interrupt routing.
        dev_irq = 6'b000101;
        #1;
`ifdef BRIDGE_IRQ_SYNC_EN
        chk("irq_sync_early", 32'(HWInt), 32'h0);
        step(); step();
`endif
        chk("irq_000101", 32'(HWInt), 32'h05);
        for (int k = 0; k < 8; k++) begin
            irq_v = 6'($urandom);
            dev_irq = irq_v;
            #1;
`ifdef BRIDGE_IRQ_SYNC_EN
            step(); step();
`endif
            chk("irq_rand", 32'(HWInt), 32'(irq_v));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
